irq_generator: RTL and testbench

IRQ_GENERATOR -- requirements
Module: irq_generator

---
 rtl/irq_generator.sv | 156 +++++++++++++++
 tb/tb_irq_generator.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_generator.sv
// -----------------------------------------------------------------------------
// irq_generator
//
// Memory-mapped interrupt controller. It collects rising edges on 16 event
// lines, software set requests and an optional periodic timer into a sticky
// PENDING register. PENDING is gated by ENABLE (bit 0 is an NMI and is never
// masked) and driven out as registered level interrupts.
//
// Register map (32-bit bus, full-address decode):
//   0xFFFF_FF10  PENDING    read; write-1-to-clear
//   0xFFFF_FF14  ENABLE     read/write, bits 15:0
//   0xFFFF_FF18  SWSET      write-1-to-set pending; reads 0
//   0xFFFF_FF1C  TIMER_CMP  read/write, bits TIMER_W-1:0 (timer build only)
//
// Optional feature: define IRQ_TIMER_EN to build the periodic timer source
// on pending[1]. Without it TIMER_CMP reads 0 and ignores writes.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   event_in      peripheral event levels (rising edge = event)
//   data_address  CPU data-bus address
//   write_en      bus write strobe
//   write_data    bus write data
//   read_data     registered read data for the previous-cycle address
//   irq_out       level interrupt lines, bit 0 = NMI
// -----------------------------------------------------------------------------
module irq_generator #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] event_in,
  input  logic [31:0] data_address,
  input  logic        write_en,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [15:0] irq_out
);

  localparam logic [31:0] ADDR_PENDING = 32'hFFFF_FF10;
  localparam logic [31:0] ADDR_ENABLE  = 32'hFFFF_FF14;
  localparam logic [31:0] ADDR_SWSET   = 32'hFFFF_FF18;
  localparam logic [31:0] ADDR_CMP     = 32'hFFFF_FF1C;

  logic [15:0] event_q;
  logic [15:0] pending_q, pending_d;
  logic [15:0] enable_q,  enable_d;
  logic [15:0] irq_q,     irq_d;
  logic [31:0] rdata_q,   rdata_d;

  logic wr_pending, wr_enable, wr_swset, wr_cmp;
  logic timer_hit;
  logic [31:0] cmp_rd;

  assign wr_pending = write_en && (data_address == ADDR_PENDING);
  assign wr_enable  = write_en && (data_address == ADDR_ENABLE);
  assign wr_swset   = write_en && (data_address == ADDR_SWSET);
  assign wr_cmp     = write_en && (data_address == ADDR_CMP);

  // Upper write-data bits are only meaningful for a full-width TIMER_CMP.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^write_data[31:16];

`ifdef IRQ_TIMER_EN
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] cmp_q, cmp_d;

  // Counter runs 0..cmp-1 and fires on the wrap, giving one event every
  // cmp cycles. Writing TIMER_CMP restarts the period from zero.
  always_comb begin
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    timer_hit = 1'b0;
    if (wr_cmp) begin
      cmp_d = write_data[TIMER_W-1:0];
      cnt_d = '0;
    end else if (cmp_q == '0) begin
      cnt_d = '0;
    end else if (cnt_q == cmp_q - TIMER_W'(1)) begin
      cnt_d     = '0;
      timer_hit = 1'b1;
    end else begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      cmp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
    end
  end

  assign cmp_rd = 32'(cmp_q);
`else
  logic unused_wr_cmp;
  assign unused_wr_cmp = wr_cmp;
  assign timer_hit     = 1'b0;
  assign cmp_rd        = '0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [15:0] set_mask;
    logic [15:0] clr_mask;

    set_mask = event_in & ~event_q;
    if (wr_swset) set_mask = set_mask | write_data[15:0];
    set_mask[1] = set_mask[1] | timer_hit;

    clr_mask = wr_pending ? write_data[15:0] : 16'h0000;

    // Clear is applied before set so a coincident source event wins.
    pending_d = (pending_q & ~clr_mask) | set_mask;

    enable_d = wr_enable ? write_data[15:0] : enable_q;

    // NMI (bit 0) bypasses the enable mask.
    irq_d = {pending_q[15:1] & enable_q[15:1], pending_q[0]};

    rdata_d = '0;
    case (data_address)
      ADDR_PENDING: rdata_d = {16'h0000, pending_q};
      ADDR_ENABLE:  rdata_d = {16'h0000, enable_q};
      ADDR_CMP:     rdata_d = cmp_rd;
      default:      rdata_d = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // pre-edge values; the asynchronous reset clears outputs without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_q   <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      irq_q     <= '0;
      rdata_q   <= '0;
    end else begin
      event_q   <= event_in;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign read_data = rdata_q;
  assign irq_out   = irq_q;

endmodule

// File: tb/tb_irq_generator.sv
// -----------------------------------------------------------------------------
// tb_irq_generator
//
// Directed testbench for irq_generator. Each scenario task drives the bus and
// event lines and compares outputs against hand-derived values. Inputs change
// and outputs are sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_irq_generator;

  localparam logic [31:0] A_PEND = 32'hFFFF_FF10;
  localparam logic [31:0] A_EN   = 32'hFFFF_FF14;
  localparam logic [31:0] A_SW   = 32'hFFFF_FF18;
  localparam logic [31:0] A_CMP  = 32'hFFFF_FF1C;

  logic        clk;
  logic        rst_n;
  logic [15:0] event_in;
  logic [31:0] data_address;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [15:0] irq_out;

  int n_checks = 0;
  int n_pass   = 0;

  irq_generator #(.TIMER_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .event_in     (event_in),
    .data_address (data_address),
    .write_en     (write_en),
    .write_data   (write_data),
    .read_data    (read_data),
    .irq_out      (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    data_address = addr;
    write_data   = data;
    write_en     = 1'b1;
    tick();
    write_en     = 1'b0;
    write_data   = '0;
    data_address = '0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    data_address = addr;
    write_en     = 1'b0;
    tick();
    data         = read_data;
    data_address = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL reset_irq: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    n_checks++;
    if (read_data !== 32'h0) $display("FAIL reset_rdata: read_data=%h expected 00000000", read_data);
    else n_pass++;
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_pending: read=%h expected 00000000", rd);
    else n_pass++;
    read_reg(A_EN, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_enable: read=%h expected 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_edge_event();
    logic [31:0] rd;
    write_reg(A_EN, 32'h0000_0008);
    event_in[3] = 1'b1;
    tick();
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL edge_irq_n1: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    tick();
    n_checks++;
    if (irq_out !== 16'h0008) $display("FAIL edge_irq_n2: irq_out=%h expected 0008", irq_out);
    else n_pass++;
    repeat (4) tick();
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0000_0008) $display("FAIL edge_pending: read=%h expected 00000008", rd);
    else n_pass++;
    // Clear while the level stays high: must not re-trigger.
    write_reg(A_PEND, 32'h0000_0008);
    n_checks++;
    if (irq_out !== 16'h0008) $display("FAIL edge_w1c_m1: irq_out=%h expected 0008", irq_out);
    else n_pass++;
    tick();
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL edge_w1c_m2: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    repeat (3) tick();
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL edge_no_retrigger: read=%h expected 00000000", rd);
    else n_pass++;
    event_in[3] = 1'b0;
    tick();
  endtask

  task automatic test_nmi();
    logic [31:0] rd;
    write_reg(A_EN, 32'h0000_0000);
    event_in[0] = 1'b1;
    event_in[2] = 1'b1;
    tick();
    event_in[0] = 1'b0;
    event_in[2] = 1'b0;
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL nmi_irq_n1: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    tick();
    n_checks++;
    if (irq_out !== 16'h0001) $display("FAIL nmi_irq_n2: irq_out=%h expected 0001", irq_out);
    else n_pass++;
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0000_0005) $display("FAIL nmi_pending: read=%h expected 00000005", rd);
    else n_pass++;
    write_reg(A_PEND, 32'h0000_0005);
    n_checks++;
    if (irq_out !== 16'h0001) $display("FAIL nmi_w1c_m1: irq_out=%h expected 0001", irq_out);
    else n_pass++;
    tick();
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL nmi_w1c_m2: irq_out=%h expected 0000", irq_out);
    else n_pass++;
  endtask

  task automatic test_set_clear_collision();
    logic [31:0] rd;
    event_in[5] = 1'b1;
    write_reg(A_PEND, 32'h0000_0020);
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0000_0020) $display("FAIL collision_pending: read=%h expected 00000020", rd);
    else n_pass++;
    write_reg(A_PEND, 32'h0000_0020);
    event_in[5] = 1'b0;
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL collision_cleanup: read=%h expected 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_swset();
    logic [31:0] rd;
    write_reg(A_EN, 32'h0000_FFFF);
    write_reg(A_SW, 32'h0000_8000);
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0000_8000) $display("FAIL swset_pending: read=%h expected 00008000", rd);
    else n_pass++;
    n_checks++;
    if (irq_out !== 16'h8000) $display("FAIL swset_irq: irq_out=%h expected 8000", irq_out);
    else n_pass++;
    read_reg(A_SW, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL swset_read: read=%h expected 00000000", rd);
    else n_pass++;
    write_reg(A_PEND, 32'h0000_8000);
    tick();
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL swset_clear: irq_out=%h expected 0000", irq_out);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    write_reg(A_EN, 32'hFFFF_1234);
    read_reg(A_EN, rd);
    n_checks++;
    if (rd !== 32'h0000_1234) $display("FAIL enable_hi_bits: read=%h expected 00001234", rd);
    else n_pass++;
    write_reg(32'hFFFF_FF20, 32'hFFFF_FFFF);
    write_reg(32'hFFFF_FF00, 32'hFFFF_FFFF);
    read_reg(32'hFFFF_FF20, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL unmapped_read: read=%h expected 00000000", rd);
    else n_pass++;
    read_reg(A_EN, rd);
    n_checks++;
    if (rd !== 32'h0000_1234) $display("FAIL unmapped_no_effect_en: read=%h expected 00001234", rd);
    else n_pass++;
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL unmapped_no_effect_pend: read=%h expected 00000000", rd);
    else n_pass++;
  endtask

`ifdef IRQ_TIMER_EN
  task automatic test_timer();
    logic [31:0] rd;
    write_reg(A_EN, 32'h0000_0002);
    write_reg(A_CMP, 32'd5);
    repeat (4) tick();
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL timer_early: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    tick();
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL timer_set_edge: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    tick();
    n_checks++;
    if (irq_out !== 16'h0002) $display("FAIL timer_first: irq_out=%h expected 0002", irq_out);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      write_reg(A_PEND, 32'h0000_0002);
      repeat (3) tick();
      n_checks++;
      if (irq_out !== 16'h0000) $display("FAIL timer_gap_%0d: irq_out=%h expected 0000", k, irq_out);
      else n_pass++;
      tick();
      n_checks++;
      if (irq_out !== 16'h0002) $display("FAIL timer_period_%0d: irq_out=%h expected 0002", k, irq_out);
      else n_pass++;
    end
    write_reg(A_PEND, 32'h0000_0002);
    write_reg(A_CMP, 32'd0);
    repeat (15) tick();
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL timer_halt_irq: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL timer_halt_pending: read=%h expected 00000000", rd);
    else n_pass++;
    write_reg(A_CMP, 32'h1234_5678);
    read_reg(A_CMP, rd);
    n_checks++;
    if (rd !== 32'h1234_5678) $display("FAIL timer_cmp_read: read=%h expected 12345678", rd);
    else n_pass++;
    write_reg(A_CMP, 32'd0);
  endtask
`else
  task automatic test_timer();
    logic [31:0] rd;
    write_reg(A_EN, 32'h0000_0002);
    write_reg(A_CMP, 32'd5);
    read_reg(A_CMP, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL notimer_cmp_read: read=%h expected 00000000", rd);
    else n_pass++;
    repeat (12) tick();
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL notimer_irq: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL notimer_pending: read=%h expected 00000000", rd);
    else n_pass++;
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] rd;
    write_reg(A_EN, 32'h0000_FFFF);
    write_reg(A_SW, 32'h0000_FFFF);
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0000_FFFF) $display("FAIL ares_pending_pre: read=%h expected 0000ffff", rd);
    else n_pass++;
    n_checks++;
    if (irq_out !== 16'hFFFF) $display("FAIL ares_irq_pre: irq_out=%h expected ffff", irq_out);
    else n_pass++;
    // Assert reset mid-cycle with a write in flight; outputs must drop at once.
    data_address = A_SW;
    write_data   = 32'h0000_FFFF;
    write_en     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL ares_irq: irq_out=%h expected 0000", irq_out);
    else n_pass++;
    n_checks++;
    if (read_data !== 32'h0) $display("FAIL ares_rdata: read_data=%h expected 00000000", read_data);
    else n_pass++;
    tick();
    tick();
    write_en     = 1'b0;
    write_data   = '0;
    data_address = '0;
    rst_n        = 1'b1;
    read_reg(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL ares_pending_post: read=%h expected 00000000", rd);
    else n_pass++;
    read_reg(A_EN, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL ares_enable_post: read=%h expected 00000000", rd);
    else n_pass++;
    n_checks++;
    if (irq_out !== 16'h0000) $display("FAIL ares_irq_post: irq_out=%h expected 0000", irq_out);
    else n_pass++;
  endtask

  initial begin
    rst_n        = 1'b0;
    event_in     = '0;
    data_address = '0;
    write_en     = 1'b0;
    write_data   = '0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_edge_event();
    test_nmi();
    test_set_clear_collision();
    test_swset();
    test_unmapped();
    test_timer();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
